nbit_divider: RTL

NBIT_DIVIDER -- requirements
Module: nbit_divider

---
 rtl/divider_pkg.sv | 12 +
 rtl/nbit_subtractor.sv | 25 ++
 rtl/nbit_divider.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default width.
package divider_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nbit_subtractor.sv
// (N+1)-bit ripple-borrow subtractor used for the divider's trial subtraction.
module nbit_subtractor
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N:0] a,
  input  logic [N:0] b,
  output logic [N:0] diff,
  output logic       borrow
);

  logic br_chain;

  always_comb begin
    diff     = '0;
    br_chain = 1'b0;
    for (int i = 0; i <= N; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br_chain;
      br_chain = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br_chain);
    end
    borrow = br_chain;
  end

endmodule

// File: rtl/nbit_divider.sv
// Restoring shift-subtract divider: one quotient bit per CALC cycle, results N+1 cycles after start.
// Define NBIT_DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module nbit_divider
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N:0]    rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  dvs_q;

  logic [N:0]    shift_d;
  logic [N:0]    diff_d;
  logic [N:0]    rem_d;
  logic [N-1:0]  quo_d;
  logic          borrow_d;
  logic          accept_d;
  logic [N-1:0]  load_quo_d;
  logic [N-1:0]  load_dvs_d;
  logic [N-1:0]  res_quo_d;
  logic [N-1:0]  res_rem_d;
  logic          unused_rem_msb;

  assign accept_d = start && (state_q != CALC);

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign shift_d = {rem_q[N-1:0], quo_q[N-1]};

  nbit_subtractor #(.N(N)) u_sub (
    .a      (shift_d),
    .b      ({1'b0, dvs_q}),
    .diff   (diff_d),
    .borrow (borrow_d)
  );

  assign rem_d          = borrow_d ? shift_d : diff_d;
  assign quo_d          = {quo_q[N-2:0], ~borrow_d};
  assign unused_rem_msb = rem_q[N];

`ifdef NBIT_DIVIDER_SIGNED_EN
  logic qneg_q;
  logic rneg_q;

  function automatic logic [N-1:0] twos_neg(input logic [N-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    return v[N-1] ? twos_neg(v) : v;
  endfunction

  assign load_quo_d = mag(dividend);
  assign load_dvs_d = mag(divisor);
  assign res_quo_d  = qneg_q ? twos_neg(quo_q) : quo_q;
  assign res_rem_d  = rneg_q ? twos_neg(rem_q[N-1:0]) : rem_q[N-1:0];

  // Zero-divisor results bypass sign correction so the raw dividend comes back unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept_d) begin
      qneg_q <= (divisor != '0) && (dividend[N-1] ^ divisor[N-1]);
      rneg_q <= (divisor != '0) && dividend[N-1];
    end
  end
`else
  assign load_quo_d = dividend;
  assign load_dvs_d = divisor;
  assign res_quo_d  = quo_q;
  assign res_rem_d  = rem_q[N-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state_q)
        CALC: begin
          if (cnt_q == LAST) begin
            state_q   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= res_quo_d;
            remainder <= res_rem_d;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          if (accept_d) begin
            state_q  <= CALC;
            busy     <= 1'b1;
            div_zero <= (divisor == '0);
            // A zero divisor jumps straight to the final count so DONE follows on the next edge.
            if (divisor == '0) begin
              cnt_q <= LAST;
              rem_q <= {1'b0, dividend};
              quo_q <= '1;
              dvs_q <= '0;
            end else begin
              cnt_q <= '0;
              rem_q <= '0;
              quo_q <= load_quo_d;
              dvs_q <= load_dvs_d;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
